// File: rtl/uart_tx_pkg.sv
// Shared encodings between the UART TX control FSM and its transmit datapath.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    MUX_START = 2'b00,
    MUX_IDLE  = 2'b01,
    MUX_SER   = 2'b10,
    MUX_PAR   = 2'b11
  } mux_sel_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// LSB-first shift register with a wrapping bit counter; flags the last data bit.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;

  // Load wins over shifting so a fresh byte always starts from bit 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      bit_cnt   <= '0;
    end else if (ser_en) begin
      shift_reg <= shift_reg >> 1;
      bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    end
  end

  assign ser_data = shift_reg[0];
  assign ser_done = ser_en && (bit_cnt == LAST_BIT);

endmodule

// File: rtl/uart_tx_datapath.sv
// UART TX datapath: latches byte and parity, serializes, and drives the registered line.
module uart_tx_datapath
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_TYP,
  input  logic                  ser_en,
  input  logic [1:0]            mux_sel,
  output logic                  ser_done,
  output logic                  TX_OUT
);

  logic load;
  logic ser_data;
  logic par_bit;

  // Only accept a new byte while the FSM is idle or sending the stop bit.
  assign load = Data_Valid && (mux_sel == MUX_IDLE);

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .load_data(P_DATA),
    .ser_en   (ser_en),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_bit <= 1'b0;
    end else if (load) begin
      par_bit <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
    end
  end

  // Line lags the FSM state by one cycle; reset forces it idle-high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TX_OUT <= 1'b1;
    end else begin
      case (mux_sel)
        MUX_START: TX_OUT <= 1'b0;
        MUX_IDLE:  TX_OUT <= 1'b1;
        MUX_SER:   TX_OUT <= ser_data;
        default:   TX_OUT <= par_bit;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Self-checking bench for uart_tx_datapath: frame-level model plus directed frames.
module tb_uart_tx_datapath;
  import uart_tx_pkg::*;

  localparam int DW = 8;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_TYP;
  logic          ser_en;
  logic [1:0]    mux_sel;
  logic          ser_done;
  logic          TX_OUT;

  int total = 0;
  int bad   = 0;

  // Model state: latched byte kept whole, indexed by number of bits consumed.
  logic [DW-1:0] m_byte = '0;
  logic          m_par  = 1'b0;
  int            m_idx  = 0;
  logic          exp_tx = 1'b1;

  uart_tx_datapath #(.DATA_WIDTH(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_TYP   (PAR_TYP),
    .ser_en    (ser_en),
    .mux_sel   (mux_sel),
    .ser_done  (ser_done),
    .TX_OUT    (TX_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Line value is whatever the previous cycle's state selected.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_byte = '0;
      m_par  = 1'b0;
      m_idx  = 0;
      exp_tx = 1'b1;
    end else begin
      case (mux_sel)
        2'b00:   exp_tx = 1'b0;
        2'b01:   exp_tx = 1'b1;
        2'b10:   exp_tx = m_byte[m_idx];
        default: exp_tx = m_par;
      endcase
      if (Data_Valid && mux_sel == 2'b01) begin
        m_byte = P_DATA;
        m_par  = PAR_TYP ^ (^P_DATA);
        m_idx  = 0;
      end else if (ser_en) begin
        m_idx = (m_idx + 1) % DW;
      end
    end
  end

  always @(negedge CLK) begin
    checkOutput("model_tx", TX_OUT, exp_tx);
    checkOutput("model_done", ser_done, ser_en && (m_idx == DW - 1));
  end

  task automatic applyStimulus(input logic [1:0] ms, input logic se, input logic dv,
                               input logic [DW-1:0] d, input logic pt);
    @(posedge CLK);
    #1;
    mux_sel    = ms;
    ser_en     = se;
    Data_Valid = dv;
    P_DATA     = d;
    PAR_TYP    = pt;
    @(negedge CLK);
  endtask

  // Drives start, 8 serial cycles, optional parity, then stop (optionally loading the next byte).
  task automatic runFrame(input logic [DW-1:0] d, input logic pt, input logic do_load,
                          input logic do_par, input logic exp_par, input int glitch_at,
                          input logic nxt_dv, input logic [DW-1:0] nxt_d, input logic nxt_pt);
    if (do_load) applyStimulus(MUX_IDLE, 1'b0, 1'b1, d, pt);
    applyStimulus(MUX_START, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("pre_start_high", TX_OUT, 1'b1);
    for (int i = 0; i < DW; i++) begin
      applyStimulus(MUX_SER, 1'b1, (i == glitch_at), 8'h3C, 1'b1);
      checkOutput($sformatf("tx_bit%0d", i), TX_OUT, (i == 0) ? 1'b0 : d[i-1]);
      checkOutput($sformatf("done_cyc%0d", i), ser_done, (i == DW - 1));
    end
    if (do_par) begin
      applyStimulus(MUX_PAR, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("tx_last_data", TX_OUT, d[DW-1]);
    end
    applyStimulus(MUX_IDLE, 1'b0, nxt_dv, nxt_d, nxt_pt);
    checkOutput(do_par ? "tx_parity" : "tx_last_data", TX_OUT, do_par ? exp_par : d[DW-1]);
  endtask

  initial begin
    RST        = 1'b0;
    mux_sel    = MUX_IDLE;
    ser_en     = 1'b0;
    Data_Valid = 1'b0;
    P_DATA     = '0;
    PAR_TYP    = 1'b0;
    #1 RST = 1'b1;
    #2;
    checkOutput("reset_tx", TX_OUT, 1'b1);
    checkOutput("reset_done", ser_done, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    #2 RST = 1'b0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(MUX_IDLE, 1'b0, 1'b0, 8'hFF, 1'b0);
      checkOutput("idle_tx", TX_OUT, 1'b1);
      checkOutput("idle_done", ser_done, 1'b0);
    end

    // A5 even parity -> 0, odd parity -> 1; 00 without parity state.
    runFrame(8'hA5, PAR_EVEN, 1'b1, 1'b1, 1'b0, -1, 1'b0, '0, 1'b0);
    applyStimulus(MUX_IDLE, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("stop_bit", TX_OUT, 1'b1);
    runFrame(8'hA5, PAR_ODD, 1'b1, 1'b1, 1'b1, -1, 1'b0, '0, 1'b0);
    runFrame(8'h00, PAR_EVEN, 1'b1, 1'b0, 1'b0, -1, 1'b0, '0, 1'b0);
    applyStimulus(MUX_IDLE, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("stop_bit_nopar", TX_OUT, 1'b1);

    // Back-to-back: 01 loaded during FF's stop bit; 01 even parity is 1.
    runFrame(8'hFF, PAR_EVEN, 1'b1, 1'b1, 1'b0, -1, 1'b1, 8'h01, PAR_EVEN);
    runFrame(8'h01, PAR_EVEN, 1'b0, 1'b1, 1'b1, -1, 1'b0, '0, 1'b0);

    // Data_Valid with 3C in the 4th serial cycle must be ignored.
    runFrame(8'hA5, PAR_EVEN, 1'b1, 1'b1, 1'b0, 3, 1'b0, '0, 1'b0);

    // Reset during the 5th data bit.
    applyStimulus(MUX_IDLE, 1'b0, 1'b1, 8'hA5, PAR_EVEN);
    applyStimulus(MUX_START, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(MUX_SER, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("before_rst_bit3", TX_OUT, 1'b0);
    #1 RST = 1'b1;
    #1;
    checkOutput("rst_tx_async", TX_OUT, 1'b1);
    checkOutput("rst_done", ser_done, 1'b0);
    mux_sel = MUX_IDLE;
    ser_en  = 1'b0;
    @(negedge CLK);
    #2 RST = 1'b0;
    runFrame(8'h81, PAR_EVEN, 1'b1, 1'b1, 1'b0, -1, 1'b0, '0, 1'b0);
    applyStimulus(MUX_IDLE, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("final_stop", TX_OUT, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
